regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 SHALL have the following ports (name  direction  width  meaning):
- Clk  in  1  system clock, rising-edge.
- Reset  in  1  synchronous active-high reset.
- A_Valid  in  1  execute-stage writeback request.
- A_DR  in  3  execute destination register.
- A_Data  in  16  execute writeback value.
- A_Ready  out  1  execute request accepted this cycle.
- B_Valid  in  1  memory-stage writeback request.
- B_DR  in  3  memory destination register.
- B_Data  in  16  memory writeback value.
- B_Ready  out  1  memory request accepted this cycle.
- Rsv_Valid  in  1  issue stage reserves a destination register.
- Rsv_DR  in  3  register being reserved.
- LD_REG  out  1  register-file write enable.
- DR  out  3  register-file write address.
- In  out  16  register-file write data.
- Busy  out  8  per-register pending-write scoreboard; bit n = Rn.

Function
REQ-003 SHALL accept at most one request per cycle; a transfer occurs when X_Valid and X_Ready are both high.
REQ-004 A_Ready/B_Ready SHALL be combinational from the Valid inputs and Last_Grant; they are never both high.
REQ-005 Only one requester valid: grant it, regardless of Last_Grant.
REQ-006 Both valid: grant the requester not in Last_Grant (round-robin); the loser holds Valid/DR/Data stable until granted.
REQ-007 Last_Grant SHALL update on every transfer to the granted requester; it is unchanged in idle cycles.
REQ-008 LD_REG, DR and In SHALL be registered: the edge that completes a transfer loads DR/In from the winner and sets LD_REG=1 for exactly one cycle; latency is 1 cycle from accept to LD_REG.
REQ-009 No transfer in a cycle: LD_REG=0 next cycle; DR/In hold their previous values.
REQ-010 Back-to-back transfers SHALL produce LD_REG high on consecutive cycles with no bubble.
REQ-011 Rsv_Valid SHALL set Busy[Rsv_DR] at the next edge.
REQ-012 Busy[DR] SHALL clear at the edge where LD_REG=1 (the register-file commit edge).
REQ-013 Set and clear of the same bit on the same edge: set wins (a newer reservation survives an older commit).
REQ-014 Reserve of an already-busy register: Busy stays 1 (no counting); the first commit clears it.
REQ-015 Writebacks to a register whose Busy bit is 0 SHALL still be performed; Busy is advisory only.
REQ-016 Two consecutive commits to the same DR SHALL preserve grant order; the later-granted data is the final register value.

Reset
REQ-017 While Reset=1: LD_REG=0, DR=0, In=0, Busy=8'h00, Last_Grant=B (so A has first priority), A_Ready=B_Ready=0.
REQ-018 A transfer in flight (accepted but LD_REG not yet pulsed) when Reset asserts SHALL be discarded; no write issues after Reset.
REQ-019 The first cycle after Reset deasserts SHALL accept requests normally.

Structure
REQ-020 A shared package regfile_pkg SHALL hold REG_W=16, REG_ADDR_W=3, NUM_REGS=8, typedef reg_addr_t and reg_data_t, and enum grant_t {GRANT_A, GRANT_B}; the register file and this block both import it.
REQ-021 The two-way round-robin grant logic SHALL be a sub-module rr_arb2 (inputs req[1:0], Last_Grant state; outputs gnt[1:0]); write-port registers and scoreboard stay in the top.

Verification
REQ-022 Only A_Valid, A_DR=3, A_Data=16'hCAFE -> A_Ready=1 same cycle; next cycle LD_REG=1, DR=3, In=16'hCAFE; following cycle LD_REG=0.
REQ-023 After reset, A and B valid together (A: R2/16'hBEEF, B: R2/16'h1234), held until granted -> A granted first, B next cycle; LD_REG high two consecutive cycles; R2 ends 16'h1234.
REQ-024 Both valid continuously for 6 cycles -> grants alternate A,B,A,B,A,B; never both Ready high.
REQ-025 Rsv_DR=5 reserve, then B writes R5 16'h00FF -> Busy=8'h20 until the LD_REG=1 edge, then 8'h00; with Rsv_DR=5 re-asserted on that edge, Busy stays 8'h20.
REQ-026 Accept A (R7/16'hAAAA) with Reset asserted on the next edge -> LD_REG stays 0, Busy=8'h00, R7 unchanged.
REQ-027 B writes R0 16'h5555 with Busy[0]=0 -> write performed, Busy stays 8'h00.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared register-file definitions.
// Holds the register-file geometry, the address and data types, and the
// writeback grant encoding. The register file and the writeback arbiter
// both import this package.
package regfile_pkg;

  localparam int REG_W      = 16;
  localparam int REG_ADDR_W = 3;
  localparam int NUM_REGS   = 8;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_W-1:0]      reg_data_t;

  typedef enum logic {
    GRANT_A = 1'b0,
    GRANT_B = 1'b1
  } grant_t;

  // One-hot mask that selects register 'addr' in a per-register bit vector.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input reg_addr_t addr);
    return NUM_REGS'(1) << addr;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-way round-robin grant logic for the writeback port.
// Ports:
//   req[1:0]   : request vector, bit 0 = execute (A), bit 1 = memory (B)
//   Last_Grant : requester that won the most recent transfer
//   gnt[1:0]   : one-hot grant (all zero when nothing requests)
// Purely combinational; the Last_Grant state lives in the instantiating block.
module rr_arb2
  import regfile_pkg::*;
(
  input  logic [1:0] req,
  input  grant_t     Last_Grant,
  output logic [1:0] gnt
);

  // Lone requester always wins; on contention the one not granted last wins.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11: begin
        if (Last_Grant == GRANT_A) begin
          gnt = 2'b10;
        end else begin
          gnt = 2'b01;
        end
      end
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter with pending-write scoreboard.
// Merges the execute-stage (A) and memory-stage (B) writeback requests onto
// the single register-file write port, alternating between them when both
// request, and tracks which registers have a writeback still outstanding.
// Ports:
//   Clk, Reset                  : clock and synchronous active-high reset
//   A_Valid/A_DR/A_Data/A_Ready : execute writeback request handshake
//   B_Valid/B_DR/B_Data/B_Ready : memory writeback request handshake
//   Rsv_Valid/Rsv_DR            : issue-stage destination reservation
//   LD_REG/DR/In                : registered register-file write port
//   Busy                        : per-register pending-write bits (bit n = Rn)
module regfile_wb_arbiter
  import regfile_pkg::*;
(
  input  logic                Clk,
  input  logic                Reset,
  input  logic                A_Valid,
  input  logic [2:0]          A_DR,
  input  logic [15:0]         A_Data,
  output logic                A_Ready,
  input  logic                B_Valid,
  input  logic [2:0]          B_DR,
  input  logic [15:0]         B_Data,
  output logic                B_Ready,
  input  logic                Rsv_Valid,
  input  logic [2:0]          Rsv_DR,
  output logic                LD_REG,
  output logic [2:0]          DR,
  output logic [15:0]         In,
  output logic [7:0]          Busy
);

  logic [1:0]          w_gnt;
  logic                w_xfer;
  reg_addr_t           w_sel_dr;
  reg_data_t           w_sel_data;
  logic [NUM_REGS-1:0] w_busy_nxt;

  grant_t              r_last_grant;
  logic                r_ld_reg;
  reg_addr_t           r_dr;
  reg_data_t           r_in;
  logic [NUM_REGS-1:0] r_busy;

  rr_arb2 u_rr_arb2 (
    .req        ({B_Valid, A_Valid}),
    .Last_Grant (r_last_grant),
    .gnt        (w_gnt)
  );

  // Handshake readies are suppressed during reset so nothing is accepted.
  always_comb begin
    A_Ready = w_gnt[0] & ~Reset;
    B_Ready = w_gnt[1] & ~Reset;
    w_xfer  = A_Ready | B_Ready;
  end

  // Select destination and data of the winning requester.
  always_comb begin
    w_sel_dr   = A_DR;
    w_sel_data = A_Data;
    if (w_gnt[1]) begin
      w_sel_dr   = B_DR;
      w_sel_data = B_Data;
    end else begin
      w_sel_dr   = A_DR;
      w_sel_data = A_Data;
    end
  end

  // Scoreboard update: commit clears first, then a reservation sets, so a
  // newer reservation to the same register survives the older commit.
  always_comb begin
    w_busy_nxt = r_busy;
    if (r_ld_reg) begin
      w_busy_nxt = w_busy_nxt & ~reg_onehot(r_dr);
    end else begin
      w_busy_nxt = w_busy_nxt;
    end
    if (Rsv_Valid) begin
      w_busy_nxt = w_busy_nxt | reg_onehot(Rsv_DR);
    end else begin
      w_busy_nxt = w_busy_nxt;
    end
  end

  // Round-robin state: remember the winner of each transfer.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_last_grant <= GRANT_B;
    end else if (w_xfer) begin
      r_last_grant <= w_gnt[1] ? GRANT_B : GRANT_A;
    end
  end

  // Write-port registers: one-cycle LD_REG pulse per transfer; address and
  // data hold their last values between transfers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_ld_reg <= 1'b0;
      r_dr     <= '0;
      r_in     <= '0;
    end else begin
      r_ld_reg <= w_xfer;
      if (w_xfer) begin
        r_dr <= w_sel_dr;
        r_in <= w_sel_data;
      end
    end
  end

  // Pending-write scoreboard register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  assign LD_REG = r_ld_reg;
  assign DR     = r_dr;
  assign In     = r_in;
  assign Busy   = r_busy;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed testbench for regfile_wb_arbiter.
module tb_regfile_wb_arbiter;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        A_Valid, B_Valid, Rsv_Valid;
  logic [2:0]  A_DR, B_DR, Rsv_DR;
  logic [15:0] A_Data, B_Data;
  logic        A_Ready, B_Ready, LD_REG;
  logic [2:0]  DR;
  logic [15:0] In;
  logic [7:0]  Busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Register-file model written from the DUT's write port.
  logic [15:0] rf [8] = '{default: 16'h0000};

  regfile_wb_arbiter dut (
    .Clk(Clk), .Reset(Reset),
    .A_Valid(A_Valid), .A_DR(A_DR), .A_Data(A_Data), .A_Ready(A_Ready),
    .B_Valid(B_Valid), .B_DR(B_DR), .B_Data(B_Data), .B_Ready(B_Ready),
    .Rsv_Valid(Rsv_Valid), .Rsv_DR(Rsv_DR),
    .LD_REG(LD_REG), .DR(DR), .In(In), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (LD_REG) rf[DR] <= In;
  end

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    A_Valid = 1'b0; A_DR = 3'd0; A_Data = 16'h0000;
    B_Valid = 1'b0; B_DR = 3'd0; B_Data = 16'h0000;
    Rsv_Valid = 1'b0; Rsv_DR = 3'd0;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    Reset = 1'b1;
    A_Valid = 1'b1; B_Valid = 1'b1; Rsv_Valid = 1'b1; Rsv_DR = 3'd4;
    tick();
    tick();
    #1;
    n_checks++; if (A_Ready !== 1'b0) begin n_fail++; $display("FAIL rst_a_ready: got %b exp 0", A_Ready); end
    n_checks++; if (B_Ready !== 1'b0) begin n_fail++; $display("FAIL rst_b_ready: got %b exp 0", B_Ready); end
    n_checks++; if (LD_REG !== 1'b0) begin n_fail++; $display("FAIL rst_ld_reg: got %b exp 0", LD_REG); end
    n_checks++; if (DR !== 3'd0) begin n_fail++; $display("FAIL rst_dr: got %0d exp 0", DR); end
    n_checks++; if (In !== 16'h0000) begin n_fail++; $display("FAIL rst_in: got %h exp 0000", In); end
    n_checks++; if (Busy !== 8'h00) begin n_fail++; $display("FAIL rst_busy: got %h exp 00", Busy); end
    idle();
    Reset = 1'b0;
    tick();
  endtask

  task automatic test_single_a();
    A_Valid = 1'b1; A_DR = 3'd3; A_Data = 16'hCAFE;
    #1;
    n_checks++; if (A_Ready !== 1'b1) begin n_fail++; $display("FAIL single_a_ready: got %b exp 1", A_Ready); end
    n_checks++; if (B_Ready !== 1'b0) begin n_fail++; $display("FAIL single_b_ready: got %b exp 0", B_Ready); end
    tick();
    idle();
    n_checks++; if (LD_REG !== 1'b1) begin n_fail++; $display("FAIL single_ld: got %b exp 1", LD_REG); end
    n_checks++; if (DR !== 3'd3) begin n_fail++; $display("FAIL single_dr: got %0d exp 3", DR); end
    n_checks++; if (In !== 16'hCAFE) begin n_fail++; $display("FAIL single_in: got %h exp cafe", In); end
    tick();
    n_checks++; if (LD_REG !== 1'b0) begin n_fail++; $display("FAIL single_ld_drop: got %b exp 0", LD_REG); end
    n_checks++; if (In !== 16'hCAFE) begin n_fail++; $display("FAIL single_in_hold: got %h exp cafe", In); end
    n_checks++; if (rf[3] !== 16'hCAFE) begin n_fail++; $display("FAIL single_r3: got %h exp cafe", rf[3]); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    A_Valid = 1'b1; A_DR = 3'd2; A_Data = 16'hBEEF;
    B_Valid = 1'b1; B_DR = 3'd2; B_Data = 16'h1234;
    #1;
    n_checks++; if ({A_Ready, B_Ready} !== 2'b10) begin n_fail++; $display("FAIL b2b_first_grant: got %b exp 10", {A_Ready, B_Ready}); end
    tick();
    A_Valid = 1'b0;
    #1;
    n_checks++; if (LD_REG !== 1'b1 || In !== 16'hBEEF) begin n_fail++; $display("FAIL b2b_a_commit: got ld=%b in=%h exp ld=1 in=beef", LD_REG, In); end
    n_checks++; if ({A_Ready, B_Ready} !== 2'b01) begin n_fail++; $display("FAIL b2b_second_grant: got %b exp 01", {A_Ready, B_Ready}); end
    tick();
    idle();
    n_checks++; if (LD_REG !== 1'b1 || In !== 16'h1234 || DR !== 3'd2) begin n_fail++; $display("FAIL b2b_b_commit: got ld=%b dr=%0d in=%h exp ld=1 dr=2 in=1234", LD_REG, DR, In); end
    tick();
    n_checks++; if (LD_REG !== 1'b0) begin n_fail++; $display("FAIL b2b_ld_drop: got %b exp 0", LD_REG); end
    n_checks++; if (rf[2] !== 16'h1234) begin n_fail++; $display("FAIL b2b_r2_final: got %h exp 1234", rf[2]); end
  endtask

  task automatic test_alternate();
    // Last winner was B, so A leads the alternation.
    A_Valid = 1'b1; A_DR = 3'd1; A_Data = 16'hAAA1;
    B_Valid = 1'b1; B_DR = 3'd4; B_Data = 16'hBBB2;
    for (int i = 0; i < 6; i++) begin
      #1;
      n_checks++;
      if ((i % 2 == 0 && {A_Ready, B_Ready} !== 2'b10) || (i % 2 == 1 && {A_Ready, B_Ready} !== 2'b01)) begin
        n_fail++; $display("FAIL alt_grant_%0d: got %b exp %s", i, {A_Ready, B_Ready}, (i % 2 == 0) ? "10" : "01");
      end
      tick();
      n_checks++;
      if (LD_REG !== 1'b1 || In !== ((i % 2 == 0) ? 16'hAAA1 : 16'hBBB2)) begin
        n_fail++; $display("FAIL alt_commit_%0d: got ld=%b in=%h", i, LD_REG, In);
      end
    end
    idle();
    tick();
    n_checks++; if (LD_REG !== 1'b0) begin n_fail++; $display("FAIL alt_ld_drop: got %b exp 0", LD_REG); end
  endtask

  task automatic test_busy();
    Rsv_Valid = 1'b1; Rsv_DR = 3'd5;
    tick();
    Rsv_Valid = 1'b0;
    n_checks++; if (Busy !== 8'h20) begin n_fail++; $display("FAIL busy_set: got %h exp 20", Busy); end
    B_Valid = 1'b1; B_DR = 3'd5; B_Data = 16'h00FF;
    #1;
    n_checks++; if (B_Ready !== 1'b1) begin n_fail++; $display("FAIL busy_b_ready: got %b exp 1", B_Ready); end
    tick();
    B_Valid = 1'b0;
    n_checks++; if (LD_REG !== 1'b1 || Busy !== 8'h20) begin n_fail++; $display("FAIL busy_before_commit: got ld=%b busy=%h exp ld=1 busy=20", LD_REG, Busy); end
    // Re-reserve R5 on the commit edge: the reservation must survive.
    Rsv_Valid = 1'b1; Rsv_DR = 3'd5;
    tick();
    Rsv_Valid = 1'b0;
    n_checks++; if (Busy !== 8'h20) begin n_fail++; $display("FAIL busy_set_wins: got %h exp 20", Busy); end
    B_Valid = 1'b1; B_DR = 3'd5; B_Data = 16'h0F0F;
    tick();
    B_Valid = 1'b0;
    n_checks++; if (Busy !== 8'h20) begin n_fail++; $display("FAIL busy_hold: got %h exp 20", Busy); end
    tick();
    n_checks++; if (Busy !== 8'h00) begin n_fail++; $display("FAIL busy_clear: got %h exp 00", Busy); end
    n_checks++; if (rf[5] !== 16'h0F0F) begin n_fail++; $display("FAIL busy_r5: got %h exp 0f0f", rf[5]); end
  endtask

  task automatic test_reset_in_flight();
    Rsv_Valid = 1'b1; Rsv_DR = 3'd7;
    tick();
    Rsv_Valid = 1'b0;
    A_Valid = 1'b1; A_DR = 3'd7; A_Data = 16'hAAAA;
    #1;
    n_checks++; if (A_Ready !== 1'b1) begin n_fail++; $display("FAIL flight_a_ready: got %b exp 1", A_Ready); end
    Reset = 1'b1;
    tick();
    idle();
    n_checks++; if (LD_REG !== 1'b0) begin n_fail++; $display("FAIL flight_ld: got %b exp 0", LD_REG); end
    n_checks++; if (Busy !== 8'h00) begin n_fail++; $display("FAIL flight_busy: got %h exp 00", Busy); end
    Reset = 1'b0;
    tick();
    n_checks++; if (LD_REG !== 1'b0) begin n_fail++; $display("FAIL flight_ld_after: got %b exp 0", LD_REG); end
    n_checks++; if (rf[7] !== 16'h0000) begin n_fail++; $display("FAIL flight_r7: got %h exp 0000", rf[7]); end
  endtask

  task automatic test_unreserved_write();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    // First cycle out of reset: request must be accepted immediately.
    B_Valid = 1'b1; B_DR = 3'd0; B_Data = 16'h5555;
    #1;
    n_checks++; if (B_Ready !== 1'b1) begin n_fail++; $display("FAIL unres_b_ready: got %b exp 1", B_Ready); end
    tick();
    idle();
    n_checks++; if (LD_REG !== 1'b1 || DR !== 3'd0 || In !== 16'h5555) begin n_fail++; $display("FAIL unres_commit: got ld=%b dr=%0d in=%h exp ld=1 dr=0 in=5555", LD_REG, DR, In); end
    tick();
    n_checks++; if (Busy !== 8'h00) begin n_fail++; $display("FAIL unres_busy: got %h exp 00", Busy); end
    n_checks++; if (rf[0] !== 16'h5555) begin n_fail++; $display("FAIL unres_r0: got %h exp 5555", rf[0]); end
  endtask

  initial begin
    idle();
    Reset = 1'b1;
    #2;
    test_reset();
    test_single_a();
    test_back_to_back();
    test_alternate();
    test_busy();
    test_reset_in_flight();
    test_unreserved_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
